cskip_mp_scheduler: RTL and testbench
=====================================

// Module: cskip_mp_scheduler
// PURPOSE
//  Shares one 32-bit carry-skip adder core (thirty_two_bit_cskip) among NREQ requesters.
//  Runs multi-precision adds of WORDS*32 bits serially, one 32-bit word per cycle, LSW first.
//  Carries the carry-out of each word into the next word.
//  Sits between requesting datapath units and the adder core, in front of the result consumer.
// PARAMETERS
//  NREQ   2  number of requesters (>=1)
//  WORDS  4  32-bit words per operand; operand width W = 32*WORDS (>=1)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  req_valid  in   NREQ       requester i has an operation pending
//  req_ready  out  NREQ       grant; a transfer occurs when req_valid[i]&req_ready[i]
//  req_a      in   NREQ*W     operand A; requester i occupies bits [i*W +: W]
//  req_b      in   NREQ*W     operand B, same packing as req_a
//  req_cin    in   NREQ       carry-in for requester i
//  rsp_valid  out  1          result available
//  rsp_ready  in   1          consumer accepts the result
//  rsp_id     out  max(1,$clog2(NREQ))  index of the requester that owns the result
//  rsp_sum    out  W          sum, modulo 2^W
//  rsp_cout   out  1          carry-out of the most-significant word
//  busy       out  1          high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0.
//   Round-robin pointer resets so that requester 0 has the highest priority.
//  FSM states:
//   IDLE -> RUN on an accepted request.
//   RUN stays for exactly WORDS cycles (word counter k = 0..WORDS-1), then goes to DONE.
//   DONE -> IDLE when rsp_ready=1.
//  IDLE:
//   Exactly one req_ready bit is high: the first requester with req_valid=1, searching
//    upward from (last grant + 1) mod NREQ.
//   req_ready is combinational from req_valid and state. It never depends on rsp_ready.
//   No req_ready bit is high outside IDLE, or when no requester is valid.
//   On accept: latch A, B, cin and the id. Advance the pointer to the granted index. Set k=0.
//  RUN, cycle k:
//   Drive adder inputs a=A[32k+:32], b=B[32k+:32], c0 = cin (k=0) or the registered carry (k>0).
//   Register s into sum[32k+:32] and cout into the carry register.
//  Latency: the accept edge is E0. rsp_valid rises after edge E(WORDS).
//   rsp_sum, rsp_cout and rsp_id are stable while rsp_valid=1.
//  DONE:
//   Hold rsp_valid=1 until rsp_ready=1. Deassert on that edge and go to IDLE.
//   A new grant is possible in the next cycle, so there is 1 bubble between operations.
//  A requester that drops req_valid before it is granted is simply skipped. No state is kept for it.
//  Operands are captured on accept. Input changes after accept do not affect the result.
//  NREQ=1: the arbiter degenerates; req_ready[0] = req_valid[0] & IDLE.
//  WORDS=1: the RUN phase lasts a single cycle.
//  rst asserted mid-RUN or mid-DONE aborts the operation immediately.
//   The result is lost and all outputs return to their reset values.
// CONFIGURATION
//  CSKIP_SCHED_OVF_EN defined:
//   Adds output rsp_ovf (1 bit) = signed two's-complement overflow of the W-bit add,
//    i.e. carry into MSB XOR carry out of MSB.
//   rsp_ovf is registered with the final word, valid with rsp_valid, reset value 0.
//  CSKIP_SCHED_OVF_EN not defined: no rsp_ovf port and no associated logic.
// STRUCTURE
//  Package cskip_sched_pkg:
//   localparam WORD_W=32.
//   typedef enum {S_IDLE, S_RUN, S_DONE} state_t.
//   function clog2_min1 for the rsp_id width.
//  Sub-module rr_arbiter #(NREQ):
//   inputs: req, enable, advance
//   outputs: one-hot gnt, gnt_idx
//   internal: pointer register
//  Adder core: a single thirty_two_bit_cskip instance, fed by the word mux.
// TESTING
//  1. NREQ=2, WORDS=4; req0: A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1, cin=0
//     -> sum=0x0000_0000_0000_0001_0000_0000_0000_0000, cout=0, id=0;
//     rsp_valid exactly 4 cycles after the accept edge.
//  2. Both requesters valid every cycle, rsp_ready=1
//     -> grants alternate 0,1,0,1; rsp_id follows the same order; 1-cycle bubble between ops.
//  3. A=B=all-ones (128b), cin=1 -> sum=all-ones, cout=1;
//     with CSKIP_SCHED_OVF_EN: rsp_ovf=0.
//     A=0x7FFF..F, B=1 -> rsp_ovf=1, cout=0.
//  4. rsp_ready held 0 for 10 cycles in DONE
//     -> rsp_valid and data stable, req_ready=0 throughout;
//     accept on rsp_ready=1, grant possible in the next cycle.
//  5. Change req_a during RUN -> result equals the captured operands.
//     req1 valid for 1 cycle while busy -> never granted, no response.
//  6. Assert rst at k=2 of RUN -> all outputs 0 the same cycle.
//     After release, requester 0 wins a simultaneous request and the result is correct.

Source files
------------

// File: rtl/cskip_sched_pkg.sv
// Shared types and helpers for the multi-precision carry-skip scheduler.
// Word width, FSM encoding and an index-width helper that never returns zero.
package cskip_sched_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cskip_mp_scheduler_arb.sv
// Round-robin arbiter: one-hot grant searching upward from (last grant + 1).
// Grant is combinational; pointer moves only when advance is asserted.
module rr_arbiter
  import cskip_sched_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = clog2_min1(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);
  logic [IW-1:0] ptr;
  logic          found;
  int            idx;

  // Pointer starts at the last index so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= IW'(NREQ - 1);
    else if (advance) ptr <= gnt_idx;
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int o = 1; o <= NREQ; o++) begin
      idx = int'(ptr) + o;
      if (idx >= NREQ) idx = idx - NREQ;
      if (enable && !found && req[idx[IW-1:0]]) begin
        found               = 1'b1;
        gnt[idx[IW-1:0]]    = 1'b1;
        gnt_idx             = idx[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/thirty_two_bit_cskip.sv
// 32-bit carry-skip adder: 8 ripple blocks of 4 bits, carry bypasses fully-propagating blocks.
// Purely combinational; no flow control.
module thirty_two_bit_cskip (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c0,
  output logic [31:0] s,
  output logic        cout
);
  logic [31:0] p;
  logic [31:0] g;
  logic [8:0]  bc;
  logic        rc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    s     = '0;
    bc    = '0;
    rc    = 1'b0;
    bc[0] = c0;
    for (int j = 0; j < 8; j++) begin
      rc = bc[j];
      for (int i = 0; i < 4; i++) begin
        s[4*j+i] = p[4*j+i] ^ rc;
        rc       = g[4*j+i] | (p[4*j+i] & rc);
      end
      // A block whose bits all propagate passes its carry-in straight through.
      bc[j+1] = (&p[4*j +: 4]) ? bc[j] : rc;
    end
  end

  assign cout = bc[8];
endmodule

// File: rtl/cskip_mp_scheduler.sv
// Shares one 32-bit carry-skip adder across NREQ requesters; W-bit add done LSW first, WORDS cycles, result held until rsp_ready.
// Optional CSKIP_SCHED_OVF_EN adds rsp_ovf (signed overflow); one idle bubble between operations.
module cskip_mp_scheduler
  import cskip_sched_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int WORDS = 4,
  localparam int W     = WORD_W * WORDS,
  localparam int IW    = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
`ifdef CSKIP_SCHED_OVF_EN
  output logic              rsp_ovf,
`endif
  output logic              busy
);
  localparam int KW = clog2_min1(WORDS);

  state_t        state_q, state_d;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic          accept;
  logic          last;
  logic [KW-1:0] k;
  logic [W-1:0]  a_q, b_q, sel_a, sel_b;
  logic          cin_q, sel_cin, carry_q;
  logic [WORD_W-1:0] a_w, b_w, s_w;
  logic          c_w, cout_w;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .enable  ((state_q == S_IDLE) && !rst),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);
  assign last      = (k == KW'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
        sel_cin = req_cin[i];
      end
    end
  end

  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k == KW'(i)) begin
        a_w = a_q[i*WORD_W +: WORD_W];
        b_w = b_q[i*WORD_W +: WORD_W];
      end
    end
    c_w = (k == '0) ? cin_q : carry_q;
  end

  thirty_two_bit_cskip u_add (
    .a    (a_w),
    .b    (b_w),
    .c0   (c_w),
    .s    (s_w),
    .cout (cout_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      k        <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
`ifdef CSKIP_SCHED_OVF_EN
      rsp_ovf  <= 1'b0;
`endif
    end else begin
      if (state_q == S_IDLE && accept) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        cin_q  <= sel_cin;
        rsp_id <= gnt_idx;
        k      <= '0;
      end
      if (state_q == S_RUN) begin
        for (int i = 0; i < WORDS; i++) begin
          if (k == KW'(i)) rsp_sum[i*WORD_W +: WORD_W] <= s_w;
        end
        carry_q <= cout_w;
        if (last) begin
          rsp_cout <= cout_w;
`ifdef CSKIP_SCHED_OVF_EN
          // Carry into the MSB is recovered as a^b^s at bit 31.
          rsp_ovf  <= a_w[WORD_W-1] ^ b_w[WORD_W-1] ^ s_w[WORD_W-1] ^ cout_w;
`endif
        end else begin
          k <= k + KW'(1);
        end
      end
    end
  end

  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_cskip_mp_scheduler.sv
// Directed self-checking bench for cskip_mp_scheduler (NREQ=2, WORDS=4).
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_cskip_mp_scheduler;
  localparam int NREQ  = 2;
  localparam int WORDS = 4;
  localparam int W     = 128;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [1:0]      req_cin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [0:0]      rsp_id;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
`ifdef CSKIP_SCHED_OVF_EN
  logic            rsp_ovf;
`endif
  logic            busy;

  int n_chk;
  int n_fail;

  cskip_mp_scheduler #(.NREQ(NREQ), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
`ifdef CSKIP_SCHED_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_cin[idx]      = cin;
  endtask

  // Raise mask, wait for the expected grant, pass the accept edge, then wait for the result.
  task automatic issue(input logic [1:0] mask, input int exp_idx, output int lat);
    int n;
    logic [1:0] e;
    e = 2'b01 << exp_idx;
    req_valid = mask;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk("grant", req_ready, e);
    cyc();
    req_valid = 2'b00;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      cyc();
      lat++;
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("take_clr", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int ng, nresp, last_g, seen;
    logic stop;
    logic [W-1:0] hold_sum;
    logic [1:0] exp_order [4];
    logic [W-1:0] exp_sum [2];
    logic exp_cout [2];

    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    req_valid = 2'b00;
    req_a = '0;
    req_b = '0;
    req_cin = 2'b00;
    rsp_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cyc();

    // 1: 64-bit carry ripple across the word boundary, latency 4.
    set_req(0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0);
    issue(2'b01, 0, lat);
    chk("t1_lat", lat, 4);
    chk("t1_sum", rsp_sum, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
    chk("t1_cout", rsp_cout, 0);
    chk("t1_id", rsp_id, 0);
    chk("t1_busy", busy, 1);
    take();

    // 2: both valid, rsp_ready high; last grant was 0 so order is 1,0,1,0.
    set_req(0, 128'h5, 128'h7, 1'b0);
    set_req(1, 128'hFFFF_FFFF_0000_0000_0000_0000_0000_0000,
               128'hFFFF_FFFF_0000_0000_0000_0000_0000_0000, 1'b1);
    exp_sum[0]  = 128'hC;
    exp_cout[0] = 1'b0;
    exp_sum[1]  = 128'hFFFF_FFFE_0000_0000_0000_0000_0000_0001;
    exp_cout[1] = 1'b1;
    exp_order[0] = 2'd1;
    exp_order[1] = 2'd0;
    exp_order[2] = 2'd1;
    exp_order[3] = 2'd0;
    ng = 0;
    nresp = 0;
    last_g = 0;
    stop = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 80 && nresp < 4; i++) begin
      if (stop) begin
        req_valid = 2'b00;
        #1;
      end
      if (rsp_valid) begin
        chk("t2_rsp_id", rsp_id, exp_order[nresp]);
        chk("t2_sum", rsp_sum, exp_sum[rsp_id]);
        chk("t2_cout", rsp_cout, exp_cout[rsp_id]);
        nresp++;
      end
      if (|(req_valid & req_ready)) begin
        chk("t2_gnt", req_ready, 2'b01 << exp_order[ng]);
        if (ng > 0) chk("t2_gap", i - last_g, WORDS + 2);
        last_g = i;
        ng++;
        if (ng == 4) stop = 1'b1;
      end
      cyc();
    end
    chk("t2_nresp", nresp, 4);
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    cyc();

    // 3: all-ones plus all-ones plus 1; then signed overflow at the MSB.
    set_req(0, {W{1'b1}}, {W{1'b1}}, 1'b1);
    issue(2'b01, 0, lat);
    chk("t3a_lat", lat, 4);
    chk("t3a_sum", rsp_sum, {W{1'b1}});
    chk("t3a_cout", rsp_cout, 1);
`ifdef CSKIP_SCHED_OVF_EN
    chk("t3a_ovf", rsp_ovf, 0);
`endif
    take();
    cyc();
    set_req(0, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0);
    issue(2'b01, 0, lat);
    chk("t3b_sum", rsp_sum, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    chk("t3b_cout", rsp_cout, 0);
`ifdef CSKIP_SCHED_OVF_EN
    chk("t3b_ovf", rsp_ovf, 1);
`endif
    take();
    cyc();

    // 4: consumer stalls 10 cycles in DONE while both requesters wait.
    set_req(1, 128'h1_0000_0000, 128'h2_0000_0003, 1'b0);
    issue(2'b10, 1, lat);
    chk("t4_sum0", rsp_sum, 128'h3_0000_0003);
    hold_sum = 128'h3_0000_0003;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_valid", rsp_valid, 1);
      chk("t4_hold", rsp_sum, hold_sum);
      chk("t4_rdy0", req_ready, 0);
      cyc();
    end
    chk("t4_id", rsp_id, 1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("t4_done", rsp_valid, 0);
    chk("t4_next_gnt", req_ready, 2'b01);
    req_valid = 2'b00;
    cyc();

    // 5: operands captured at accept; a brief request while busy is dropped.
    set_req(0, 128'h1234_5678, 128'h1111_1111, 1'b0);
    req_valid = 2'b01;
    #1;
    chk("t5_gnt", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    req_a = {2*W{1'b1}};
    cyc();
    req_valid = 2'b10;
    #1;
    chk("t5_busy_rdy", req_ready, 0);
    cyc();
    req_valid = 2'b00;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      cyc();
      lat++;
    end
    chk("t5_sum", rsp_sum, 128'h2345_6789);
    chk("t5_id", rsp_id, 0);
    take();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || busy) seen++;
      cyc();
    end
    chk("t5_no_rsp1", seen, 0);

    // 6: reset at k=2 aborts; afterwards requester 0 wins a tie.
    set_req(0, 128'h9, 128'h9, 1'b0);
    req_valid = 2'b01;
    #1;
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_valid", rsp_valid, 0);
    chk("t6_sum", rsp_sum, 0);
    chk("t6_id", rsp_id, 0);
    chk("t6_cout", rsp_cout, 0);
    chk("t6_ready", req_ready, 0);
    cyc();
    rst = 1'b0;
    cyc();
    set_req(0, 128'h1, 128'h2, 1'b1);
    set_req(1, 128'h100, 128'h200, 1'b0);
    issue(2'b11, 0, lat);
    chk("t6_lat", lat, 4);
    chk("t6_rsum", rsp_sum, 128'h4);
    chk("t6_rid", rsp_id, 0);
    take();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
